// File: rtl/tx_fifo_pkg.sv
// Shared constants and types for the transmit word-to-byte FIFO.
// Optional word counter in tx_fifo is enabled with the TX_FIFO_COUNT_EN macro.
package tx_fifo_pkg;

   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;

   typedef logic [1:0]        byte_idx_t;
   typedef logic [WORD_W-1:0] word_t;
   typedef logic [BYTE_W-1:0] byte_t;

   // Byte lane select; lane 0 is the least significant byte.
   function automatic byte_t word_byte(input word_t w, input byte_idx_t idx);
      byte_t b;
      unique case (idx)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/tx_comb_output.sv
// Combinational status decode for tx_fifo: full/empty from pointers and wrap toggles,
// plus valid and last-byte indication for the head word.
module tx_comb_output #(
   parameter int unsigned PTR_W = 2
) (
   input  logic [PTR_W-1:0] head_ptr_i,
   input  logic [PTR_W-1:0] tail_ptr_i,
   input  logic             head_tog_i,
   input  logic             tail_tog_i,
   input  logic [1:0]       head_side_i,
   input  logic [1:0]       head_nb_i,
   output logic             full_o,
   output logic             empty_o,
   output logic             rd_valid_o,
   output logic             last_byte_o
);

   logic ptr_eq;

   always_comb begin
      ptr_eq      = (head_ptr_i == tail_ptr_i);
      empty_o     = ptr_eq && (head_tog_i == tail_tog_i);
      full_o      = ptr_eq && (head_tog_i != tail_tog_i);
      rd_valid_o  = !empty_o;
      last_byte_o = rd_valid_o && (head_side_i == head_nb_i);
   end

endmodule

// File: rtl/tx_fifo.sv
// Transmit FIFO: host pushes 32-bit words carrying 1-4 bytes, transmitter pops bytes
// LSB first, first-word-fall-through. TX_FIFO_COUNT_EN adds a registered word_count_o.
module tx_fifo
   import tx_fifo_pkg::*;
#(
   parameter int unsigned  DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           wr_en_i,
   input  logic [31:0]    wr_data_i,
   input  logic [1:0]     wr_nbytes_i,
   input  logic           rd_en_i,
   input  logic           clr_err_i,
   output logic [7:0]     rd_data_o,
   output logic           rd_valid_o,
   output logic           last_byte_o,
   output logic           full_o,
   output logic           empty_o,
   output logic           overflow_o,
   output logic           underflow_o
`ifdef TX_FIFO_COUNT_EN
   ,
   output logic [PTR_W:0] word_count_o
`endif
);

   localparam logic [PTR_W-1:0] PtrLast = PTR_W'(DEPTH - 1);

   word_t            mem_q [DEPTH];
   byte_idx_t        nb_q  [DEPTH];
   logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
   logic [PTR_W-1:0] tail_ptr_q, tail_ptr_d;
   logic             head_tog_q, head_tog_d;
   logic             tail_tog_q, tail_tog_d;
   byte_idx_t        head_side_q, head_side_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             push;
   logic             pop;
   logic             pop_word;
   word_t            head_word;
   byte_idx_t        head_nb;

   assign head_word = mem_q[head_ptr_q];
   assign head_nb   = nb_q[head_ptr_q];

   tx_comb_output #(
      .PTR_W (PTR_W)
   ) u_status (
      .head_ptr_i  (head_ptr_q),
      .tail_ptr_i  (tail_ptr_q),
      .head_tog_i  (head_tog_q),
      .tail_tog_i  (tail_tog_q),
      .head_side_i (head_side_q),
      .head_nb_i   (head_nb),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .rd_valid_o  (rd_valid_o),
      .last_byte_o (last_byte_o)
   );

   always_comb begin
      push      = wr_en_i && !full_o;
      pop       = rd_en_i && !empty_o;
      pop_word  = pop && last_byte_o;
      rd_data_o = word_byte(head_word, head_side_q);
   end

   always_comb begin
      tail_ptr_d  = tail_ptr_q;
      tail_tog_d  = tail_tog_q;
      head_ptr_d  = head_ptr_q;
      head_tog_d  = head_tog_q;
      head_side_d = head_side_q;

      if (push) begin
         tail_ptr_d = tail_ptr_q + 1'b1;
         if (tail_ptr_q == PtrLast) begin
            tail_tog_d = ~tail_tog_q;
         end
      end

      if (pop) begin
         if (last_byte_o) begin
            head_side_d = '0;
            head_ptr_d  = head_ptr_q + 1'b1;
            if (head_ptr_q == PtrLast) begin
               head_tog_d = ~head_tog_q;
            end
         end else begin
            head_side_d = head_side_q + 1'b1;
         end
      end

      // A fresh error in the clearing cycle keeps the flag set.
      overflow_d  = (overflow_q && !clr_err_i) || (wr_en_i && full_o);
      underflow_d = (underflow_q && !clr_err_i) || (rd_en_i && empty_o);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_ptr_q  <= '0;
         tail_ptr_q  <= '0;
         head_tog_q  <= 1'b0;
         tail_tog_q  <= 1'b0;
         head_side_q <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         head_ptr_q  <= head_ptr_d;
         tail_ptr_q  <= tail_ptr_d;
         head_tog_q  <= head_tog_d;
         tail_tog_q  <= tail_tog_d;
         head_side_q <= head_side_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
            nb_q[i]  <= '0;
         end
      end else if (push) begin
         mem_q[tail_ptr_q] <= wr_data_i;
         nb_q[tail_ptr_q]  <= wr_nbytes_i;
      end
   end

   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;

`ifdef TX_FIFO_COUNT_EN
   logic [PTR_W:0] count_q, count_d;

   // Occupancy counts whole words; a word leaves only when its last byte is popped.
   always_comb begin
      count_d = count_q;
      if (push && !pop_word) begin
         count_d = count_q + 1'b1;
      end else if (pop_word && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign word_count_o = count_q;
`else
   logic unused_pop_word;
   assign unused_pop_word = pop_word;
`endif

endmodule

// File: tb/tb_tx_fifo.sv
// Bench for tx_fifo: directed scenarios plus random traffic, checked against a byte-queue
// reference model by a negedge monitor. Define TX_FIFO_COUNT_EN to also check word_count_o.
module tb_tx_fifo;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [1:0]  wr_nbytes;
   logic        rd_en;
   logic        clr_err;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        last_byte;
   logic        full;
   logic        empty;
   logic        overflow;
   logic        underflow;
`ifdef TX_FIFO_COUNT_EN
   logic [2:0]  word_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] data;
      bit         last;
   } exp_t;

   exp_t exp_q[$];
   int   m_words = 0;
   bit   m_ovf   = 0;
   bit   m_unf   = 0;

   tx_fifo #(
      .DEPTH (DEPTH)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .wr_en_i      (wr_en),
      .wr_data_i    (wr_data),
      .wr_nbytes_i  (wr_nbytes),
      .rd_en_i      (rd_en),
      .clr_err_i    (clr_err),
      .rd_data_o    (rd_data),
      .rd_valid_o   (rd_valid),
      .last_byte_o  (last_byte),
      .full_o       (full),
      .empty_o      (empty),
      .overflow_o   (overflow),
      .underflow_o  (underflow)
`ifdef TX_FIFO_COUNT_EN
      ,
      .word_count_o (word_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs are applied for exactly one cycle; returns just after the edge.
   task automatic step(input bit wr, input logic [31:0] d, input logic [1:0] nb,
                       input bit rd, input bit clr);
      wr_en     = wr;
      wr_data   = d;
      wr_nbytes = nb;
      rd_en     = rd;
      clr_err   = clr;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
   endtask

   // Monitor + scoreboard: compares DUT outputs with the model, then applies this cycle's
   // issued stimulus to the model (full/empty judged before the cycle's pop/push).
   always @(negedge clk) begin
      bit m_full;
      bit m_empty;
      if (rst) begin
         exp_q.delete();
         m_words = 0;
         m_ovf   = 0;
         m_unf   = 0;
      end else begin
         m_full  = (m_words == DEPTH);
         m_empty = (exp_q.size() == 0);
         check("rd_valid", rd_valid, !m_empty);
         check("empty", empty, m_empty);
         check("full", full, m_full);
         check("overflow", overflow, m_ovf);
         check("underflow", underflow, m_unf);
`ifdef TX_FIFO_COUNT_EN
         check("word_count", word_count, m_words);
`endif
         if (!m_empty) begin
            check("rd_data", rd_data, exp_q[0].data);
            check("last_byte", last_byte, exp_q[0].last);
         end else begin
            check("last_byte_empty", last_byte, 1'b0);
         end
         if (rd_en && !m_empty) begin
            if (exp_q[0].last) m_words--;
            void'(exp_q.pop_front());
         end
         if (wr_en && !m_full) begin
            for (int i = 0; i <= int'(wr_nbytes); i++) begin
               exp_t e;
               e.data = wr_data[8*i +: 8];
               e.last = (i == int'(wr_nbytes));
               exp_q.push_back(e);
            end
            m_words++;
         end
         m_ovf = (m_ovf && !clr_err) || (wr_en && m_full);
         m_unf = (m_unf && !clr_err) || (rd_en && m_empty);
      end
   end

   initial begin
      rst       = 1'b1;
      wr_en     = 1'b0;
      wr_data   = '0;
      wr_nbytes = '0;
      rd_en     = 1'b0;
      clr_err   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_empty", empty, 1'b1);
      check("rst_full", full, 1'b0);
      check("rst_valid", rd_valid, 1'b0);
      check("rst_last", last_byte, 1'b0);
`ifdef TX_FIFO_COUNT_EN
      check("rst_count", word_count, 0);
`endif
      rst = 1'b0;

      // One 4-byte word, drained LSB first.
      step(1, 32'hDDCC_BBAA, 2'd3, 0, 0);
      check("t1_valid", rd_valid, 1'b1);
      check("t1_b0", rd_data, 8'hAA);
      check("t1_last0", last_byte, 1'b0);
      step(0, '0, '0, 1, 0);
      check("t1_b1", rd_data, 8'hBB);
      step(0, '0, '0, 1, 0);
      check("t1_b2", rd_data, 8'hCC);
      step(0, '0, '0, 1, 0);
      check("t1_b3", rd_data, 8'hDD);
      check("t1_last3", last_byte, 1'b1);
      step(0, '0, '0, 1, 0);
      check("t1_empty", empty, 1'b1);

      // Fill with single-byte words, overflow, drain in order.
      for (int k = 1; k <= DEPTH; k++) step(1, 32'hFFFF_FF00 | k, 2'd0, 0, 0);
      check("t2_full", full, 1'b1);
      step(1, 32'h0000_00EE, 2'd0, 0, 0);
      check("t2_ovf", overflow, 1'b1);
      check("t2_full_kept", full, 1'b1);
      for (int k = 1; k <= DEPTH; k++) begin
         check("t2_byte", rd_data, k);
         check("t2_last", last_byte, 1'b1);
         step(0, '0, '0, 1, 0);
      end
      check("t2_empty", empty, 1'b1);
      step(0, '0, '0, 0, 1);
      check("t2_ovf_clr", overflow, 1'b0);

      // Wrap: fill, partial drain, refill across the wrap point, full drain.
      for (int k = 0; k < DEPTH; k++) step(1, 32'h5A00_0000 + 32'(k * 257), 2'd1, 0, 0);
      check("t3_full", full, 1'b1);
      repeat (4) step(0, '0, '0, 1, 0);
      check("t3_not_full", full, 1'b0);
      for (int k = 0; k < 2; k++) step(1, 32'h0000_C300 + 32'(k), 2'd1, 0, 0);
      check("t3_full2", full, 1'b1);
      repeat (8) step(0, '0, '0, 1, 0);
      check("t3_empty", empty, 1'b1);

      // Underflow, clear, and error-beats-clear.
      step(0, '0, '0, 1, 0);
      check("t4_unf", underflow, 1'b1);
      check("t4_empty", empty, 1'b1);
      step(0, '0, '0, 0, 1);
      check("t4_unf_clr", underflow, 1'b0);
      step(0, '0, '0, 1, 1);
      check("t4_unf_wins", underflow, 1'b1);
      step(0, '0, '0, 0, 1);

      // Simultaneous push and last-byte pop at two entries.
      step(1, 32'h0000_0071, 2'd0, 0, 0);
      step(1, 32'h0000_0072, 2'd0, 0, 0);
      step(1, 32'h0000_0073, 2'd0, 1, 0);
`ifdef TX_FIFO_COUNT_EN
      check("t5_count", word_count, 2);
`endif
      check("t5_head", rd_data, 8'h72);
      repeat (2) step(0, '0, '0, 1, 0);
      check("t5_empty", empty, 1'b1);

      // Asynchronous reset mid-word with overflow set.
      step(1, 32'h4433_2211, 2'd3, 0, 0);
      repeat (2) step(0, '0, '0, 1, 0);
      check("t6_mid", rd_data, 8'h33);
      for (int k = 0; k < DEPTH; k++) step(1, 32'h1234_5678, 2'd3, 0, 0);
      check("t6_ovf", overflow, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("t6_empty", empty, 1'b1);
      check("t6_full", full, 1'b0);
      check("t6_valid", rd_valid, 1'b0);
      check("t6_ovf_rst", overflow, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      step(1, 32'h0A0B_0C0D, 2'd3, 0, 0);
      check("t6_side0", rd_data, 8'h0D);
      repeat (4) step(0, '0, '0, 1, 0);

      // Random traffic.
      for (int n = 0; n < 800; n++) begin
         step(($urandom_range(0, 1) == 1), $urandom, 2'($urandom_range(0, 3)),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      end

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
